alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_ctrl_if.sv | 47 ++++
 rtl/alu_ctrl_regfile.sv | 35 +++
 rtl/alu_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and address-width helper for the ALU controller.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ALU0  = 2'b00,
    OP_ALU1  = 2'b01,
    OP_LOADI = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } state_e;

  // A one-entry register file still needs a one-bit address.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction, ALU and debug bus of the ALU controller.
// ALU_CTRL_ZERO_FLAG_EN adds the registered zero flag signal.
interface alu_ctrl_if
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
);
  localparam int AW = addr_w(NREG);

  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        op;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     ra;
  logic [AW-1:0]     rb;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic              sel;
  logic [DATA_W-1:0] data_out;
  logic              cnext;
  logic              done;
  logic              carry;
  logic [AW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;
`ifdef ALU_CTRL_ZERO_FLAG_EN
  logic              zero;
`endif

  modport master (
    output instr_valid, op, rd, ra, rb, imm, data_out, cnext, dbg_addr,
    input  instr_ready, x, y, sel, done, carry, dbg_data
`ifdef ALU_CTRL_ZERO_FLAG_EN
    , input zero
`endif
  );

  modport slave (
    input  instr_valid, op, rd, ra, rb, imm, data_out, cnext, dbg_addr,
    output instr_ready, x, y, sel, done, carry, dbg_data
`ifdef ALU_CTRL_ZERO_FLAG_EN
    , output zero
`endif
  );

endinterface

// File: rtl/alu_ctrl_regfile.sv
// NREG x DATA_W register file: two operand read ports, one debug read port,
// one synchronous write port, asynchronous clear.
module alu_ctrl_regfile #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[ra];
  assign rdata_b  = mem[rb];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Three-state controller feeding an external combinational ALU from a small register file.
// ALU_CTRL_ZERO_FLAG_EN enables the registered zero flag.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_ctrl_if.slave  bus
);

  localparam int AW = addr_w(NREG);

  state_e            state, state_nx;
  logic              ready, accept, is_alu, done_nx;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr, rd_q;
  logic [DATA_W-1:0] rf_wdata, src_a, src_b;
  logic [DATA_W-1:0] x_q, y_q;
  logic              sel_q, carry_q, done_q;

  alu_ctrl_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra       (bus.ra),
    .rb       (bus.rb),
    .dbg_addr (bus.dbg_addr),
    .rdata_a  (src_a),
    .rdata_b  (src_b),
    .dbg_data (bus.dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    accept   = 1'b0;
    is_alu   = 1'b0;
    done_nx  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rd_q;
    rf_wdata = bus.data_out;
    case (state)
      ST_IDLE: begin
        ready  = 1'b1;
        accept = bus.instr_valid;
        if (accept) begin
          case (bus.op)
            OP_ALU0, OP_ALU1: begin
              is_alu   = 1'b1;
              state_nx = ST_ISSUE;
            end
            OP_LOADI: begin
              rf_we    = 1'b1;
              rf_waddr = bus.rd;
              rf_wdata = bus.imm;
              done_nx  = 1'b1;
            end
            default: done_nx = 1'b1;
          endcase
        end
      end
      ST_ISSUE: state_nx = ST_CAPTURE;
      ST_CAPTURE: begin
        rf_we    = 1'b1;
        done_nx  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operands and destination are latched only at an accepted ALU instruction and
  // then held, so LOADI/NOP never disturb what the ALU was last given.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= 1'b0;
      rd_q    <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_nx;
      if (is_alu) begin
        x_q   <= src_a;
        y_q   <= src_b;
        sel_q <= bus.op[0];
        rd_q  <= bus.rd;
      end
      if (state == ST_CAPTURE) carry_q <= bus.cnext;
    end
  end

`ifdef ALU_CTRL_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   zero_q <= 1'b0;
    else if (state == ST_CAPTURE)                 zero_q <= (bus.data_out == '0);
    else if (accept && (bus.op == 2'(OP_LOADI)))  zero_q <= (bus.imm == '0);
  end

  assign bus.zero = zero_q;
`endif

  assign bus.instr_ready = ready;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.sel         = sel_q;
  assign bus.carry       = carry_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a behavioural add/and ALU.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_ctrl_if #(.DATA_W(8), .NREG(4)) bus ();

  alu_ctrl #(.DATA_W(8), .NREG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ALU model: SEL=0 adds with carry out, SEL=1 ands with no carry.
  assign {bus.cnext, bus.data_out} = bus.sel ? {1'b0, bus.x & bus.y}
                                             : ({1'b0, bus.x} + {1'b0, bus.y});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkReg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    bus.dbg_addr = idx;
    #1;
    checkOutput(tag, bus.dbg_data, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input op_e op, input logic [1:0] rd, input logic [1:0] ra,
                               input logic [1:0] rb, input logic [7:0] imm);
    bus.instr_valid = 1'b1;
    bus.op  = op;
    bus.rd  = rd;
    bus.ra  = ra;
    bus.rb  = rb;
    bus.imm = imm;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.op = OP_NOP;
    bus.rd = '0;
    bus.ra = '0;
    bus.rb = '0;
    bus.imm = '0;
    bus.dbg_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", bus.instr_ready, 1);
    checkOutput("rst_x", bus.x, 0);
    checkOutput("rst_y", bus.y, 0);
    checkOutput("rst_sel", bus.sel, 0);
    checkOutput("rst_carry", bus.carry, 0);
    checkOutput("rst_done", bus.done, 0);
`ifdef ALU_CTRL_ZERO_FLAG_EN
    checkOutput("rst_zero", bus.zero, 0);
`endif
    checkReg("rst_r0", 2'd0, 8'h00);
    rst_n = 1'b1;

    applyStimulus(OP_LOADI, 2'd0, 2'd0, 2'd0, 8'hF0);
    checkOutput("ldi0_done", bus.done, 1);
    checkOutput("ldi0_carry", bus.carry, 0);
    checkReg("ldi0_r0", 2'd0, 8'hF0);
    applyStimulus(OP_LOADI, 2'd1, 2'd0, 2'd0, 8'h20);
    checkOutput("ldi1_done", bus.done, 1);
    checkReg("ldi1_r1", 2'd1, 8'h20);

    // ALU0 R2 = R0 + R1
    applyStimulus(OP_ALU0, 2'd2, 2'd0, 2'd1, 8'h00);
    checkOutput("add_issue_x", bus.x, 8'hF0);
    checkOutput("add_issue_y", bus.y, 8'h20);
    checkOutput("add_issue_sel", bus.sel, 0);
    checkOutput("add_issue_ready", bus.instr_ready, 0);
    checkOutput("add_issue_done", bus.done, 0);
    tick();
    checkOutput("add_capture_done", bus.done, 0);
    tick();
    checkOutput("add_done", bus.done, 1);
    checkOutput("add_carry", bus.carry, 1);
    checkReg("add_r2", 2'd2, 8'h10);
`ifdef ALU_CTRL_ZERO_FLAG_EN
    checkOutput("add_zero", bus.zero, 0);
`endif

    // ALU1 R3 = R0 & R1 with valid held and the offered instruction changing
    bus.instr_valid = 1'b1;
    bus.op = OP_ALU1; bus.rd = 2'd3; bus.ra = 2'd0; bus.rb = 2'd1;
    tick();
    bus.op = OP_LOADI; bus.rd = 2'd3; bus.imm = 8'hAA;
    checkOutput("and_issue_sel", bus.sel, 1);
    checkOutput("and_issue_ready", bus.instr_ready, 0);
    tick();
    bus.op = OP_NOP;
    checkOutput("and_capture_done", bus.done, 0);
    checkReg("and_capture_r3", 2'd3, 8'h00);
    tick();
    checkOutput("and_done", bus.done, 1);
    checkOutput("and_carry", bus.carry, 0);
    checkOutput("and_done_ready", bus.instr_ready, 1);
    checkReg("and_r3", 2'd3, 8'h20);
`ifdef ALU_CTRL_ZERO_FLAG_EN
    checkOutput("and_zero", bus.zero, 0);
`endif
    bus.op = OP_LOADI; bus.rd = 2'd1; bus.imm = 8'h5A;
    tick();
    bus.instr_valid = 1'b0;
    checkOutput("held_ldi_done", bus.done, 1);
    checkReg("held_ldi_r1", 2'd1, 8'h5A);
    checkReg("held_ldi_r3", 2'd3, 8'h20);
    checkOutput("held_ldi_x", bus.x, 8'hF0);
    checkOutput("held_ldi_y", bus.y, 8'h20);
    checkOutput("held_ldi_sel", bus.sel, 1);

    // R0 = 80 + 80 wraps to zero with carry
    applyStimulus(OP_LOADI, 2'd0, 2'd0, 2'd0, 8'h80);
    applyStimulus(OP_ALU0, 2'd0, 2'd0, 2'd0, 8'h00);
    checkOutput("wrap_issue_x", bus.x, 8'h80);
    tick();
    tick();
    checkOutput("wrap_done", bus.done, 1);
    checkOutput("wrap_carry", bus.carry, 1);
    checkReg("wrap_r0", 2'd0, 8'h00);
`ifdef ALU_CTRL_ZERO_FLAG_EN
    checkOutput("wrap_zero", bus.zero, 1);
`endif

    // NOP then LOADI back-to-back
    bus.instr_valid = 1'b1;
    bus.op = OP_NOP;
    tick();
    checkOutput("nop_done", bus.done, 1);
    bus.op = OP_LOADI; bus.rd = 2'd2; bus.imm = 8'h07;
    tick();
    bus.instr_valid = 1'b0;
    checkOutput("b2b_ldi_done", bus.done, 1);
    checkOutput("b2b_carry", bus.carry, 1);
    checkOutput("b2b_x", bus.x, 8'h80);
    checkOutput("b2b_y", bus.y, 8'h80);
    checkOutput("b2b_sel", bus.sel, 0);
    checkReg("b2b_r2", 2'd2, 8'h07);
`ifdef ALU_CTRL_ZERO_FLAG_EN
    checkOutput("b2b_zero", bus.zero, 0);
`endif

    // R3 = R0 + R1 sees the freshly written R0
    applyStimulus(OP_ALU0, 2'd3, 2'd0, 2'd1, 8'h00);
    checkOutput("fresh_x", bus.x, 8'h00);
    checkOutput("fresh_y", bus.y, 8'h5A);
    tick();
    tick();
    checkOutput("fresh_done", bus.done, 1);
    checkOutput("fresh_carry", bus.carry, 0);
    checkReg("fresh_r3", 2'd3, 8'h5A);

    // Reset pulse in CAPTURE discards R1 = R1 + R1
    applyStimulus(OP_ALU0, 2'd1, 2'd1, 2'd1, 8'h00);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_x", bus.x, 0);
    checkOutput("abort_y", bus.y, 0);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_ready", bus.instr_ready, 1);
    checkOutput("abort_carry", bus.carry, 0);
    checkReg("abort_r1", 2'd1, 8'h00);

    applyStimulus(OP_LOADI, 2'd1, 2'd0, 2'd0, 8'h33);
    checkOutput("post_rst_done", bus.done, 1);
    checkReg("post_rst_r1", 2'd1, 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
